// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, default sizes and helpers for the ff-based TCAM family
package cam_pkg;

  localparam int DEF_DEPTH  = 64;
  localparam int DEF_WIDTH  = 36;
  localparam int DEF_NPORTS = 4;

  // Never returns 0, so a 1-entry table still gets a usable address bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_AW = clog2_safe(DEF_DEPTH);

  typedef logic [DEF_AW-1:0]    addr_t;
  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef struct packed {
    logic  en;
    logic  inv;
    addr_t addr;
    word_t patt;
    word_t mask;
  } wr_req_t;

  typedef struct packed {
    logic  valid;
    logic  match;
    logic  multi;
    addr_t addr;
  } result_t;

endpackage

// File: rtl/mp_tcam_entry.sv
// rtl/mp_tcam_entry.sv - one TCAM word: valid/pattern/mask storage, port-priority write, per-port hit
module mp_tcam_entry
  import cam_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NPORTS = DEF_NPORTS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS-1:0]              wSel,
  input  logic [NPORTS-1:0]              wInv,
  input  logic [NPORTS-1:0][WIDTH-1:0]   wPatt,
  input  logic [NPORTS-1:0][WIDTH-1:0]   wMask,
  input  logic [NPORTS-1:0][WIDTH-1:0]   sPatt,
  output logic [NPORTS-1:0]              hit
);

  logic             valid_q;
  logic [WIDTH-1:0] patt_q;
  logic [WIDTH-1:0] mask_q;

  logic             sel_any;
  logic             sel_inv;
  logic [WIDTH-1:0] sel_patt;
  logic [WIDTH-1:0] sel_mask;

  // Walk from the highest port down so the lowest selecting port overrides the rest.
  always_comb begin
    sel_any  = 1'b0;
    sel_inv  = 1'b0;
    sel_patt = '0;
    sel_mask = '0;
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (wSel[p]) begin
        sel_any  = 1'b1;
        sel_inv  = wInv[p];
        sel_patt = wPatt[p];
        sel_mask = wMask[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      patt_q  <= '0;
      mask_q  <= '0;
    end else if (sel_any) begin
      if (sel_inv) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
        patt_q  <= sel_patt;
        mask_q  <= sel_mask;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int p = 0; p < NPORTS; p++) begin
      hit[p] = valid_q && (&(mask_q | ~(patt_q ^ sPatt[p])));
    end
  end

endmodule

// File: rtl/pe.sv
// rtl/pe.sv - priority encoder, lowest set request index wins
module pe #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic [N-1:0]  req,
  output logic [AW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = AW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/multi_port_g_aetcam.sv
// rtl/multi_port_g_aetcam.sv - N-port flip-flop ternary CAM with registered one-cycle search results
module multi_port_g_aetcam
  import cam_pkg::*;
#(
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  NPORTS = DEF_NPORTS,
  localparam int AW     = clog2_safe(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NPORTS-1:0]             wEn,
  input  logic [NPORTS-1:0]             wInv,
  input  logic [NPORTS-1:0][AW-1:0]     wAddr,
  input  logic [NPORTS-1:0][WIDTH-1:0]  wPatt,
  input  logic [NPORTS-1:0][WIDTH-1:0]  wMask,
  input  logic [NPORTS-1:0]             sReq,
  input  logic [NPORTS-1:0][WIDTH-1:0]  sPatt,
  output logic [NPORTS-1:0]             sValid,
  output logic [NPORTS-1:0]             match,
  output logic [NPORTS-1:0]             multi,
  output logic [NPORTS-1:0][AW-1:0]     mAddr
);

  typedef struct packed {
    logic          valid;
    logic          match;
    logic          multi;
    logic [AW-1:0] addr;
  } port_res_t;

  logic [NPORTS-1:0] wr_sel   [DEPTH];
  logic [NPORTS-1:0] ent_hit  [DEPTH];
  logic [DEPTH-1:0]  port_hit [NPORTS];
  logic [AW-1:0]     pe_idx   [NPORTS];
  logic              pe_any   [NPORTS];
  logic              pe_multi [NPORTS];
  port_res_t         res_q    [NPORTS];

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_sel[e] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        wr_sel[e][p] = wEn[p] && (wAddr[p] == AW'(e));
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    mp_tcam_entry #(
      .WIDTH  (WIDTH),
      .NPORTS (NPORTS)
    ) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .wSel  (wr_sel[e]),
      .wInv  (wInv),
      .wPatt (wPatt),
      .wMask (wMask),
      .sPatt (sPatt),
      .hit   (ent_hit[e])
    );
  end

  // Entries produce hits per port; encoders want them per entry.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      port_hit[p] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        port_hit[p][e] = ent_hit[e][p];
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    pe #(
      .N  (DEPTH),
      .AW (AW)
    ) u_pe (
      .req (port_hit[p]),
      .idx (pe_idx[p]),
      .any (pe_any[p])
    );

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign pe_multi[p] = |(port_hit[p] & (port_hit[p] - DEPTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q[p] <= '0;
      end else begin
        res_q[p].valid <= sReq[p];
        if (sReq[p]) begin
          res_q[p].match <= pe_any[p];
          res_q[p].multi <= pe_multi[p];
          res_q[p].addr  <= pe_idx[p];
        end
      end
    end

    assign sValid[p] = res_q[p].valid;
    assign match[p]  = res_q[p].match;
    assign multi[p]  = res_q[p].multi;
    assign mAddr[p]  = res_q[p].addr;
  end

endmodule

// File: tb/tb_multi_port_g_aetcam.sv
// tb/tb_multi_port_g_aetcam.sv - directed scoreboard bench for the N-port ternary CAM
module tb_multi_port_g_aetcam;

  localparam int DEPTH  = 64;
  localparam int WIDTH  = 36;
  localparam int NPORTS = 4;
  localparam int AW     = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NPORTS-1:0]             wEn;
  logic [NPORTS-1:0]             wInv;
  logic [NPORTS-1:0][AW-1:0]     wAddr;
  logic [NPORTS-1:0][WIDTH-1:0]  wPatt;
  logic [NPORTS-1:0][WIDTH-1:0]  wMask;
  logic [NPORTS-1:0]             sReq;
  logic [NPORTS-1:0][WIDTH-1:0]  sPatt;
  logic [NPORTS-1:0]             sValid;
  logic [NPORTS-1:0]             match;
  logic [NPORTS-1:0]             multi;
  logic [NPORTS-1:0][AW-1:0]     mAddr;

  multi_port_g_aetcam #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .NPORTS (NPORTS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wEn    (wEn),
    .wInv   (wInv),
    .wAddr  (wAddr),
    .wPatt  (wPatt),
    .wMask  (wMask),
    .sReq   (sReq),
    .sPatt  (sPatt),
    .sValid (sValid),
    .match  (match),
    .multi  (multi),
    .mAddr  (mAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic          match;
    logic          multi;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t             exp_q[$];
  logic             m_valid [DEPTH];
  logic [WIDTH-1:0] m_patt  [DEPTH];
  logic [WIDTH-1:0] m_mask  [DEPTH];
  logic             l_match [NPORTS];
  logic             l_multi [NPORTS];
  logic [AW-1:0]    l_addr  [NPORTS];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    wEn = '0; wInv = '0; wAddr = '0; wPatt = '0; wMask = '0;
    sReq = '0; sPatt = '0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) begin
      m_valid[e] = 1'b0; m_patt[e] = '0; m_mask[e] = '0;
    end
    for (int p = 0; p < NPORTS; p++) begin
      l_match[p] = 1'b0; l_multi[p] = 1'b0; l_addr[p] = '0;
    end
    exp_q.delete();
  endtask

  task automatic set_write(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] pt,
                           input logic [WIDTH-1:0] mk, input logic inv);
    wEn[p] = 1'b1; wInv[p] = inv; wAddr[p] = a; wPatt[p] = pt; wMask[p] = mk;
  endtask

  task automatic set_search(input int p, input logic [WIDTH-1:0] key);
    sReq[p] = 1'b1; sPatt[p] = key;
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < NPORTS; p++) begin
      check($sformatf("%s_svalid_p%0d", tag, p), 64'(sValid[p]), 64'd0);
      check($sformatf("%s_match_p%0d", tag, p), 64'(match[p]), 64'd0);
      check($sformatf("%s_multi_p%0d", tag, p), 64'(multi[p]), 64'd0);
      check($sformatf("%s_maddr_p%0d", tag, p), 64'(mAddr[p]), 64'd0);
    end
  endtask

  // One clock: predict searches from pre-edge model, apply writes, then compare.
  task automatic step(input string tag);
    logic [NPORTS-1:0] req_d;
    exp_t ex;
    req_d = sReq;
    for (int p = 0; p < NPORTS; p++) begin
      if (sReq[p]) begin
        int cnt;
        int first;
        cnt = 0; first = 0;
        for (int e = 0; e < DEPTH; e++) begin
          if (m_valid[e] && ((m_mask[e] | ~(m_patt[e] ^ sPatt[p])) == {WIDTH{1'b1}})) begin
            if (cnt == 0) first = e;
            cnt++;
          end
        end
        ex.port = p; ex.match = (cnt > 0); ex.multi = (cnt > 1); ex.addr = AW'(first);
        exp_q.push_back(ex);
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      logic blocked;
      blocked = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (wEn[q] && wAddr[q] == wAddr[p]) blocked = 1'b1;
      end
      if (wEn[p] && !blocked) begin
        if (wInv[p]) begin
          m_valid[wAddr[p]] = 1'b0;
        end else begin
          m_valid[wAddr[p]] = 1'b1;
          m_patt[wAddr[p]]  = wPatt[p];
          m_mask[wAddr[p]]  = wMask[p];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NPORTS; p++) begin
      check($sformatf("%s_svalid_p%0d", tag, p), 64'(sValid[p]), 64'(req_d[p]));
      if (req_d[p]) begin
        ex = exp_q.pop_front();
        l_match[p] = ex.match; l_multi[p] = ex.multi; l_addr[p] = ex.addr;
      end
      check($sformatf("%s_match_p%0d", tag, p), 64'(match[p]), 64'(l_match[p]));
      check($sformatf("%s_multi_p%0d", tag, p), 64'(multi[p]), 64'(l_multi[p]));
      check($sformatf("%s_maddr_p%0d", tag, p), 64'(mAddr[p]), 64'(l_addr[p]));
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    for (int p = 0; p < NPORTS; p++) set_search(p, '0);
    step("empty_search");

    set_write(0, 6'd5, 36'hA5, 36'h0F, 1'b0);
    step("wr5");
    set_search(1, 36'hA3);
    step("hit5");
    set_search(1, 36'hB5);
    step("miss5");

    set_write(0, 6'd3, 36'h0, {WIDTH{1'b1}}, 1'b0);
    set_write(1, 6'd9, 36'h0, {WIDTH{1'b1}}, 1'b0);
    step("wr_dc");
    set_search(2, 36'h123456789);
    step("multi_hit");
    set_write(3, 6'd3, 36'h0, 36'h0, 1'b1);
    step("inv3");
    set_search(2, 36'h123456789);
    step("single_hit");

    set_write(0, 6'd9, 36'h0, 36'h0, 1'b1);
    set_write(1, 6'd7, 36'h11, 36'h0, 1'b0);
    set_write(3, 6'd7, 36'h22, 36'h0, 1'b0);
    step("conflict_wr");
    set_search(0, 36'h11);
    set_search(1, 36'h22);
    step("conflict_srch");

    set_write(0, 6'd7, 36'h0, 36'h0, 1'b1);
    set_write(2, 6'd7, 36'h33, 36'h0, 1'b0);
    step("conflict_inv");
    set_search(0, 36'h11);
    set_search(3, 36'h33);
    step("conflict_inv_srch");

    set_write(0, 6'd2, 36'h55, 36'h0, 1'b0);
    set_search(1, 36'h55);
    step("rdw_old");
    set_search(1, 36'h55);
    set_search(3, 36'h55);
    step("rdw_new");
    step("hold");

    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if ($urandom_range(0, 2) == 0)
          set_write(p, AW'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? WIDTH'(3) : WIDTH'(0), ($urandom_range(0, 4) == 0));
        if ($urandom_range(0, 1) == 0)
          set_search(p, WIDTH'($urandom_range(0, 7)));
      end
      step("rand");
    end

    for (int p = 0; p < NPORTS; p++) set_search(p, 36'h55);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_search(0, 36'h55);
    set_search(1, 36'h11);
    set_search(2, 36'h123456789);
    set_search(3, 36'h0);
    step("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_port_g_aetcam.md
Name: multi_port_g_aetcam

Overview:
- Parametrised N-port, flip-flop-based ternary CAM.
- Each port has an independent write/invalidate channel and an independent search channel.
- Search results are registered, with per-port request/valid signalling, per-entry valid bits and a multi-hit flag.
- Sits in the ff-based CAM family as the generalised replacement for the fixed four-port variant; feeds lookup pipelines that need deterministic one-cycle search latency.

Parameters:
- DEPTH, 64, number of entries (power of two, >=2)
- WIDTH, 36, bits per entry
- NPORTS, 4, number of write and search ports (1..8)
- AW, $clog2(DEPTH), address width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wEn  in  NPORTS  per-port write request
- wInv  in  NPORTS  per-port op select: 1 = invalidate entry, 0 = write pattern/mask
- wAddr  in  NPORTS x AW  per-port write address
- wPatt  in  NPORTS x WIDTH  per-port write pattern
- wMask  in  NPORTS x WIDTH  per-port mask; bit 1 = don't-care
- sReq  in  NPORTS  per-port search request
- sPatt  in  NPORTS x WIDTH  per-port search key
- sValid  out  NPORTS  result valid, one cycle after sReq
- match  out  NPORTS  at least one valid entry matched
- multi  out  NPORTS  two or more valid entries matched
- mAddr  out  NPORTS x AW  lowest matching index

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all entry valid bits, patterns and masks = 0
  - sValid, match, multi, mAddr = 0
  - no entry matches after reset.
- Entry match: entry valid AND every bit satisfies (stored mask bit = 1) OR (stored pattern bit = key bit).
- Search latency is exactly 1 cycle:
  - compare uses entry state at cycle t
  - on the cycle-t rising edge, register sValid[p] = sReq[p]
  - when sReq[p] = 1, also register match/multi/mAddr.
- sReq[p] = 0: sValid[p] = 0 next cycle; match/multi/mAddr[p] hold their previous values.
- No match: match = 0, multi = 0, mAddr = 0.
- Priority: lowest matching index drives mAddr. multi = 1 iff popcount of the hit vector >= 2.
- Write (wEn = 1, wInv = 0): entry wAddr gets pattern, mask and valid = 1 at the edge.
- Invalidate (wEn = 1, wInv = 1): valid = 0; pattern and mask are left unchanged.
- Same-address conflict in one cycle: the lowest port index wins; other ports to that address are dropped silently. Writes to different addresses all commit.
- Read-during-write: a search in the same cycle as a write to entry k sees the old contents. The new contents are visible to searches issued the following cycle.
- Reset mid-operation: outputs clear immediately; a pending search result is discarded.
- All ports are symmetric except for write-conflict priority.
- No backpressure: searches are accepted every cycle on every port.

Decomposition:
- Package cam_pkg:
  - addr_t, word_t
  - per-port write struct (en, inv, addr, patt, mask)
  - per-port result struct (valid, match, multi, addr)
  - function clog2_safe
- Sub-module mp_tcam_entry, one per word:
  - holds valid/pattern/mask
  - performs the port-priority write select
  - outputs an NPORTS-wide hit vector.
- Top level:
  - write decoders
  - per-port hit-vector transpose
  - existing pe priority encoder per port
  - popcount >= 2 detector
  - output registers.

Test Plan:
- Reset, then search key 0x0 on all ports -> sValid = 1 next cycle, match = 0, multi = 0, mAddr = 0.
- Port0 writes entry 5 with patt 0xA5, mask 0x0F; port1 searches 0xA3 next cycle -> match = 1, mAddr = 5, multi = 0. Search 0xB5 -> match = 0.
- Entries 3 and 9 both set to full don't-care; port2 searches any key -> match = 1, mAddr = 3, multi = 1. Invalidate entry 3 -> next search gives mAddr = 9, multi = 0.
- Ports 1 and 3 write entry 7 in the same cycle with patterns 0x11 and 0x22 -> subsequent search 0x11 hits entry 7 and 0x22 misses.
- Write entry 2 = 0x55 and search 0x55 in the same cycle -> miss. Same search one cycle later -> match = 1, mAddr = 2.
- Assert rst_n low mid-stream with sReq high -> all outputs 0 immediately. After release, every entry is invalid.
